// File: rtl/apple1_map_pkg.sv
// Apple-1 CPU address map shared by the bus controller, video and PIA blocks.
// Holds range constants, the unmapped read value and the chip-select decoder.
package apple1_map_pkg;

  localparam logic [15:0] RamBase    = 16'h0000;
  localparam logic [15:0] PiaBase    = 16'hD010;
  localparam logic [15:0] PiaLast    = 16'hD01F;
  localparam logic [15:0] BasicBase  = 16'hE000;
  localparam logic [15:0] BasicLast  = 16'hEFFF;
  localparam logic [15:0] RomBase    = 16'hFF00;
  localparam logic [15:0] RomLast    = 16'hFFFF;
  localparam logic [7:0]  UnmappedRd = 8'hFF;

  // One-hot (or all-zero for unmapped) device select.
  typedef struct packed {
    logic ram;
    logic rom;
    logic basic;
    logic pia;
  } sel_t;

  // RAM always starts at RamBase (0), and ROM runs to the top of the space,
  // so only one bound of each is compared.
  function automatic sel_t decode_sel(input logic [15:0] addr,
                                      input logic [15:0] ram_top,
                                      input logic        basic_en);
    sel_t sel;
    sel = '0;
    if (addr <= ram_top) begin
      sel.ram = 1'b1;
    end else if (addr >= PiaBase && addr <= PiaLast) begin
      sel.pia = 1'b1;
    end else if (basic_en && addr >= BasicBase && addr <= BasicLast) begin
      sel.basic = 1'b1;
    end else if (addr >= RomBase) begin
      sel.rom = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/apple1_bus_ctrl_if.sv
// CPU and device-side bus bundle for apple1_bus_ctrl. The controller takes the
// master view; the CPU core and memory/peripheral blocks take the slave view.
interface apple1_bus_ctrl_if;

  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;

  logic [15:0] mem_addr;
  logic [7:0]  wr_data;
  logic        ram_cs;
  logic        rom_cs;
  logic        basic_cs;
  logic        pia_cs;
  logic        ram_we;
  logic        pia_we;
  logic        pia_rd;

  logic [7:0]  ram_dout;
  logic [7:0]  rom_dout;
  logic [7:0]  basic_dout;
  logic [7:0]  pia_dout;

  modport master (
    output cpu_ce, cpu_di, mem_addr, wr_data,
    output ram_cs, rom_cs, basic_cs, pia_cs, ram_we, pia_we, pia_rd,
    input  cpu_addr, cpu_we, cpu_do,
    input  ram_dout, rom_dout, basic_dout, pia_dout
  );

  modport slave (
    input  cpu_ce, cpu_di, mem_addr, wr_data,
    input  ram_cs, rom_cs, basic_cs, pia_cs, ram_we, pia_we, pia_rd,
    output cpu_addr, cpu_we, cpu_do,
    output ram_dout, rom_dout, basic_dout, pia_dout
  );

endinterface

// File: rtl/apple1_clk_en.sv
// CPU phase counter: counts 0..CLK_DIV-1 and pulses cpu_ce on the last phase.
module apple1_clk_en #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [$clog2(CLK_DIV)-1:0] cnt,
  output logic                       cpu_ce
);

  localparam int unsigned           CntW   = $clog2(CLK_DIV);
  localparam logic [CntW-1:0]       LastPh = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LastPh) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign cpu_ce = (cnt_q == LastPh);

endmodule

// File: rtl/apple1_bus_ctrl.sv
// Apple-1 CPU bus controller: clock enable, address decode, registered device
// bus and read-data capture. Define BASIC_ROM_EN to map the BASIC ROM at E000.
module apple1_bus_ctrl
  import apple1_map_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter logic [15:0] RAM_TOP = 16'h1FFF
) (
  input  logic               clk,
  input  logic               rst,
  apple1_bus_ctrl_if.master  bus
);

  localparam int unsigned     CntW   = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CapPh  = '0;
  localparam logic [CntW-1:0] RdPh   = CntW'(2);

`ifdef BASIC_ROM_EN
  localparam logic BasicEn = 1'b1;
`else
  localparam logic BasicEn = 1'b0;
`endif

  if (CLK_DIV < 4) begin : g_bad_div
    $error("apple1_bus_ctrl: CLK_DIV must be at least 4");
  end
  if (RAM_TOP >= 16'hD000) begin : g_bad_ram_top
    $error("apple1_bus_ctrl: RAM_TOP must be below 16'hD000");
  end

  logic [CntW-1:0] cnt;
  logic            ce;

  apple1_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt),
    .cpu_ce (ce)
  );

  logic cap_ph, rd_ph;
  assign cap_ph = (cnt == CapPh);
  assign rd_ph  = (cnt == RdPh);

  sel_t        sel_d, sel_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  wr_data_q;
  logic        we_q;
  logic [7:0]  cpu_di_q;
  logic [7:0]  rd_mux;

  always_comb begin
    sel_d = decode_sel(bus.cpu_addr, RAM_TOP, BasicEn);
  end

  // Devices return data one cycle after mem_addr settles, so the selects
  // captured in phase 0 still steer the mux when phase 2 samples it.
  always_comb begin
    rd_mux = UnmappedRd;
    unique case (1'b1)
      sel_q.ram:   rd_mux = bus.ram_dout;
      sel_q.rom:   rd_mux = bus.rom_dout;
`ifdef BASIC_ROM_EN
      sel_q.basic: rd_mux = bus.basic_dout;
`endif
      sel_q.pia:   rd_mux = bus.pia_dout;
      default:     rd_mux = UnmappedRd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      mem_addr_q <= 16'h0000;
      wr_data_q  <= 8'h00;
      we_q       <= 1'b0;
      cpu_di_q   <= 8'h00;
    end else begin
      if (cap_ph) begin
        sel_q      <= sel_d;
        mem_addr_q <= bus.cpu_addr;
        wr_data_q  <= bus.cpu_do;
        we_q       <= bus.cpu_we;
      end
      if (rd_ph && !we_q) begin
        cpu_di_q <= rd_mux;
      end
    end
  end

  assign bus.cpu_ce   = ce;
  assign bus.cpu_di   = cpu_di_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.ram_cs   = sel_q.ram;
  assign bus.rom_cs   = sel_q.rom;
  assign bus.basic_cs = sel_q.basic;
  assign bus.pia_cs   = sel_q.pia;

  // Strobes are built only from reset-cleared flops, so an asynchronous reset
  // kills them at once and nothing fires again before a fresh phase-0 capture.
  assign bus.ram_we = ce & sel_q.ram & we_q;
  assign bus.pia_we = ce & sel_q.pia & we_q;
  assign bus.pia_rd = rd_ph & sel_q.pia & ~we_q;

endmodule
